csi_bram_reader: RTL
====================

Name: csi_bram_reader

Overview:
Upstream read stage for the CSI output buffer. On a start pulse it sweeps one CSI frame out of a dual-port BRAM: it issues addresses, tracks the BRAM read latency, and presents each returned word (tagged with a last bit) to the small latency-absorbing FIFO that follows it. That FIFO has no upstream ready, so this block meters its reads with a credit counter sized to the FIFO depth, and words are never dropped.

Parameters:
ADDR_WIDTH, 6, BRAM address width
DATA_WIDTH, 32, CSI sample width (16b I + 16b Q)
NUM_SAMPLES, 64, words per frame; must be <= 2**ADDR_WIDTH and >= 1
READ_LATENCY, 2, BRAM enable-to-data latency in cycles (>= 1)
FIFO_DEPTH, 4, entries in the downstream FIFO (credit pool size)

Ports:
clk_in  input  1  clock
rst_n_in  input  1  reset, asynchronous assert, active-low
start_in  input  1  one-cycle pulse: a complete frame is in BRAM
busy_out  output  1  high from accepted start until done
done_out  output  1  one-cycle pulse when the last word is presented
bram_en_out  output  1  BRAM read enable
bram_addr_out  output  ADDR_WIDTH  BRAM read address
bram_dout_in  input  DATA_WIDTH  BRAM read data, valid READ_LATENCY cycles after en
m_axis_tvalid  output  1  word valid to downstream FIFO (s_axis_tvalid there)
m_axis_tdata  output  DATA_WIDTH+1  {last, sample}; bit DATA_WIDTH = last
pop_in  input  1  downstream FIFO output handshake (its m_axis_tvalid & m_axis_tready)

Behaviour:
- Reset (rst_n_in low, async): state IDLE, credits=FIFO_DEPTH, addr counter 0, pipe cleared. All outputs 0, including bram_addr_out.
- States: IDLE, READ, DRAIN.
- IDLE: start_in -> READ and busy_out=1 on the next cycle; the addr counter loads 0.
- READ: issue = (credits != 0). On issue: bram_en_out=1, bram_addr_out=counter, counter+1, and a pipe slot is tagged last if counter == NUM_SAMPLES-1. When the last address is issued -> DRAIN. If no issue, bram_en_out=0 and the address holds.
- DRAIN: no issues. When the pipe output carries last -> IDLE. In that same cycle done_out=1; busy_out drops the cycle after.
- Credits: next = credits - issue + pop_in, updated every cycle in all states. Issue is gated on the registered credits, so a same-cycle pop does not enable an issue. Width is $clog2(FIFO_DEPTH+1). pop_in at credits==FIFO_DEPTH is a protocol error: the counter saturates and a simulation assertion fires.
- Latency pipe: a READ_LATENCY-deep shift register of {valid,last} advanced every cycle. m_axis_tvalid = pipe-out valid. m_axis_tdata = {pipe-out last, bram_dout_in}, combinational from the BRAM data. Nothing in this block stalls, so at most one word per cycle emerges and it is never held.
- Guarantee: words in flight plus FIFO occupancy never exceed FIFO_DEPTH. With pop_in tied high, throughput is 1 word/cycle and the first word appears READ_LATENCY cycles after the first issue.
- start_in while busy: ignored, with no restart and no queueing.
- start_in coincident with done_out: ignored (state is not yet IDLE).
- NUM_SAMPLES=1: the first issue is also last; READ -> DRAIN after one cycle.
- Reset mid-frame: everything clears immediately and credits return to FIFO_DEPTH. The downstream FIFO shares this reset, so the credit counter and FIFO stay consistent.
- Word order is strictly address order 0..NUM_SAMPLES-1.

Decomposition:
- Package csi_pkg:
  - CSI_DATA_WIDTH=32, CSI_NUM_SUBCARRIERS=64, CSI_BRAM_LATENCY=2, CSI_FIFO_DEPTH=4
  - typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_DRAIN} csi_rd_state_t
- Sub-module bram_read_pipe(LATENCY): async-reset {valid,last} delay line. This isolates latency tracking from the FSM and credit logic.

Test Plan:
- Free-running sink: pop_in=1 continuously, BRAM[i]=i, start pulse. Expect 64 consecutive valids with data 0..63, first valid 2 cycles after the first en, last=1 only on data 63. done_out pulses once on that word; busy drops 1 cycle later.
- Blocked sink: pop_in=0. Exactly 4 enables are issued (addr 0..3), then en stays 0 and busy stays 1. Releasing pop_in for 1 cycle produces exactly one more issue (addr 4), 1 cycle later.
- Random pop_in (50%) over 3 frames against a FIFO-occupancy model. Occupancy plus in-flight never exceeds 4, and all 192 words arrive in order with no loss.
- start_in pulsed mid-frame (at word 10) and again on the done_out cycle. No restart; exactly 64 words and one done per accepted start.
- rst_n_in dropped asynchronously mid-frame (word 20, between clock edges). Outputs go to 0 immediately. After release and a new start, the frame restarts at addr 0 with a full 4 credits.
- NUM_SAMPLES=1, READ_LATENCY=1 build: a single word with last=1, and done_out on the cycle after its en.

Source files
------------

// File: rtl/csi_pkg.sv
// Shared types and defaults for the CSI output-buffer read path.
package csi_pkg;

    localparam int CSI_DATA_WIDTH      = 32;
    localparam int CSI_NUM_SUBCARRIERS = 64;
    localparam int CSI_BRAM_LATENCY    = 2;
    localparam int CSI_FIFO_DEPTH      = 4;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_READ,
        RD_DRAIN
    } csi_rd_state_t;

    // One slot of the read-latency tracker: a word is coming back, and whether it ends the frame.
    typedef struct packed {
        logic valid;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/bram_read_pipe.sv
// Delay line that follows each BRAM read enable until its data appears.
// Advances every cycle; nothing downstream can stall it.
module bram_read_pipe
    import csi_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t issue_tag,
    output rd_tag_t data_tag
);

    rd_tag_t [LATENCY:1] tag_pipe;

    // Shift the {valid,last} tags one stage per cycle; async clear drops any reads in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[1] <= issue_tag;
            for (int i = 2; i <= LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign data_tag = tag_pipe[LATENCY];

endmodule

// File: rtl/csi_bram_reader.sv
// Sweeps one CSI frame out of BRAM into a ready-less downstream FIFO.
// Reads are metered by a credit counter equal to the FIFO depth, so every
// word issued is guaranteed a slot when it returns.
module csi_bram_reader
    import csi_pkg::*;
#(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = CSI_DATA_WIDTH,
    parameter int NUM_SAMPLES  = CSI_NUM_SUBCARRIERS,
    parameter int READ_LATENCY = CSI_BRAM_LATENCY,
    parameter int FIFO_DEPTH   = CSI_FIFO_DEPTH
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  bram_en_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    input  logic [DATA_WIDTH-1:0] bram_dout_in,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH:0]   m_axis_tdata,
    input  logic                  pop_in
);

    localparam int                    CRED_W    = $clog2(FIFO_DEPTH + 1);
    localparam int                    CSUM_W    = CRED_W + 1;
    localparam logic [CRED_W-1:0]     CRED_MAX  = CRED_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_SAMPLES - 1);

    csi_rd_state_t         state;
    logic [CRED_W-1:0]     credits;
    logic [CSUM_W-1:0]     credit_sum;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  busy;
    logic                  issue;
    logic                  issue_last;
    logic                  frame_done;
    rd_tag_t               issue_tag;
    rd_tag_t               data_tag;

    // Issue only on registered credits: a pop this cycle frees a slot for next cycle, not this one.
    assign issue      = (state == RD_READ) && (credits != '0);
    assign issue_last = issue && (addr == LAST_ADDR);
    assign issue_tag  = '{valid: issue, last: issue_last};
    assign frame_done = data_tag.valid && data_tag.last;

    // Credit pool: one slot taken per read, one returned per FIFO pop. Clamped at full
    // so a stray pop cannot wrap the counter and unleash extra reads.
    assign credit_sum = {1'b0, credits} + CSUM_W'(pop_in) - CSUM_W'(issue);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            credits <= CRED_MAX;
        end else if (credit_sum > {1'b0, CRED_MAX}) begin
            credits <= CRED_MAX;
        end else begin
            credits <= credit_sum[CRED_W-1:0];
        end
    end

    // Frame sequencer: address walk in READ, wait for the tagged last word in DRAIN.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= RD_IDLE;
            addr  <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (start_in) begin
                        state <= RD_READ;
                        busy  <= 1'b1;
                        addr  <= '0;
                    end
                end
                RD_READ: begin
                    if (issue) begin
                        // Hold the final address rather than stepping past the frame.
                        if (issue_last) state <= RD_DRAIN;
                        else            addr  <= addr + 1'b1;
                    end
                end
                RD_DRAIN: begin
                    if (frame_done) begin
                        state <= RD_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    bram_read_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_pipe (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .issue_tag (issue_tag),
        .data_tag  (data_tag)
    );

    assign busy_out      = busy;
    assign done_out      = frame_done;
    assign bram_en_out   = issue;
    assign bram_addr_out = addr;
    assign m_axis_tvalid = data_tag.valid;
    // Data rides straight through from BRAM; forced to zero when no word is presented.
    assign m_axis_tdata  = data_tag.valid ? {data_tag.last, bram_dout_in} : '0;

    // A pop with every credit home means the FIFO popped a word it never received.
    credit_overflow : assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(pop_in && credits == CRED_MAX));

endmodule
